// File: rtl/alu_pkg.sv
// alu_pkg: opcode, flag-index and FSM state definitions shared by alu_comb and alu_seq.
// Build option: ALU_MUL_EN adds the iterative MUL state.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD    = 4'd0,
      OP_SUB    = 4'd1,
      OP_CMP    = 4'd2,
      OP_AND    = 4'd3,
      OP_OR     = 4'd4,
      OP_XOR    = 4'd5,
      OP_NOT    = 4'd6,
      OP_NEG    = 4'd7,
      OP_SHL    = 4'd8,
      OP_SHR    = 4'd9,
      OP_SAR    = 4'd10,
      OP_MOV    = 4'd11,
      OP_MUL    = 4'd12,
      OP_RSV13  = 4'd13,
      OP_RSV14  = 4'd14,
      OP_RSV15  = 4'd15
   } alu_op_e;

   // Bit positions inside the {Z,N,C,V} flag nibble
   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

`ifdef ALU_MUL_EN
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_MUL   = 2'd2
   } alu_state_e;
`else
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1
   } alu_state_e;
`endif

endpackage

// File: rtl/alu_comb.sv
// alu_comb: single-cycle ALU ops and flag generation. Shifts by 0 or >= WIDTH
// are resolved here; other shifts (and MUL when ALU_MUL_EN is defined) raise
// iter so the sequencer runs them over several cycles.
module alu_comb
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  alu_op_e          op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags,
   output logic             wb,
   output logic             illegal,
   output logic             iter
);

   localparam int M = WIDTH - 1;
   localparam logic [WIDTH-1:0] W_LIM = WIDTH'(WIDTH);

   logic           c;
   logic           v;
   logic           amt_zero;
   logic           amt_big;
   logic [WIDTH:0] sum;

   assign amt_zero = (b == '0);
   assign amt_big  = (b >= W_LIM);
   assign sum      = {1'b0, a} + {1'b0, b};

   // Opcode decode: result, raw carry/overflow, writeback and multi-cycle request
   always_comb begin
      result  = '0;
      c       = 1'b0;
      v       = 1'b0;
      wb      = 1'b1;
      illegal = 1'b0;
      iter    = 1'b0;
      case (op)
         OP_ADD: begin
            result = sum[M:0];
            c      = sum[WIDTH];
            v      = (a[M] == b[M]) && (result[M] != a[M]);
         end
         OP_SUB, OP_CMP: begin
            result = a - b;
            c      = (a < b);
            v      = (a[M] != b[M]) && (result[M] != a[M]);
            wb     = (op == OP_SUB);
         end
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_XOR: result = a ^ b;
         OP_NOT: result = ~b;
         OP_NEG: begin
            result = '0 - b;
            c      = |b;
            v      = b[M] & result[M];
         end
         OP_SHL, OP_SHR, OP_SAR: begin
            if (amt_zero) begin
               result = a;
            end else if (amt_big) begin
               // Everything shifted out; only SAR keeps sign copies
               if (op == OP_SAR) begin
                  result = {WIDTH{a[M]}};
                  c      = a[M];
               end
            end else begin
               iter = 1'b1;
            end
         end
         OP_MOV: result = b;
`ifdef ALU_MUL_EN
         OP_MUL: iter = 1'b1;
`endif
         default: begin
            wb      = 1'b0;
            illegal = 1'b1;
         end
      endcase
   end

   // Flag nibble; an illegal op reports all-zero flags rather than Z=1
   always_comb begin
      flags = '0;
      if (!illegal) begin
         flags[FLAG_Z] = (result == '0);
         flags[FLAG_N] = result[M];
         flags[FLAG_C] = c;
         flags[FLAG_V] = v;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU. Single-cycle ops load the output slot on the accept
// edge; shifts by 1..WIDTH-1 step one bit per clock in SHIFT; with ALU_MUL_EN
// defined, MUL runs an unsigned shift-add over WIDTH clocks in MUL.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  alu_op_e          in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [3:0]       out_flags,
   output logic             out_wb,
   output logic             out_illegal
);

   localparam int SHAMT_W = $clog2(WIDTH);
   localparam int M       = WIDTH - 1;

   alu_state_e          state;
   alu_op_e             sh_op;
   logic [M:0]          sh_val;
   logic [M:0]          sh_nxt;
   logic                sh_out;
   logic [SHAMT_W-1:0]  cnt;
   logic                accept;

   logic [M:0]          c_result;
   logic [3:0]          c_flags;
   logic                c_wb;
   logic                c_illegal;
   logic                c_iter;

   alu_comb #(.WIDTH(WIDTH)) u_comb (
      .op      (in_op),
      .a       (in_a),
      .b       (in_b),
      .result  (c_result),
      .flags   (c_flags),
      .wb      (c_wb),
      .illegal (c_illegal),
      .iter    (c_iter)
   );

   // The slot may be refilled only when empty or drained on the same edge
   assign in_ready = rst_n && (state == ST_IDLE) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   // One shift step and the bit it pushes out
   always_comb begin
      sh_nxt = sh_val;
      sh_out = 1'b0;
      case (sh_op)
         OP_SHL: begin
            sh_nxt = {sh_val[M-1:0], 1'b0};
            sh_out = sh_val[M];
         end
         OP_SHR: begin
            sh_nxt = {1'b0, sh_val[M:1]};
            sh_out = sh_val[0];
         end
         OP_SAR: begin
            sh_nxt = {sh_val[M], sh_val[M:1]};
            sh_out = sh_val[0];
         end
         default: ;
      endcase
   end

`ifdef ALU_MUL_EN
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] acc_nxt;
   logic [M:0]         mplier;

   assign acc_nxt = acc + (mplier[0] ? mcand : '0);
`endif

   // FSM, iterative datapath and registered output slot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         sh_op       <= OP_ADD;
         sh_val      <= '0;
         cnt         <= '0;
         out_valid   <= 1'b0;
         out_result  <= '0;
         out_flags   <= '0;
         out_wb      <= 1'b0;
         out_illegal <= 1'b0;
`ifdef ALU_MUL_EN
         acc         <= '0;
         mcand       <= '0;
         mplier      <= '0;
`endif
      end else begin
         if (out_valid && out_ready) out_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (c_iter) begin
`ifdef ALU_MUL_EN
                     if (in_op == OP_MUL) begin
                        acc    <= '0;
                        mcand  <= {{WIDTH{1'b0}}, in_a};
                        mplier <= in_b;
                        cnt    <= SHAMT_W'(WIDTH - 1);
                        state  <= ST_MUL;
                     end else
`endif
                     begin
                        sh_op  <= in_op;
                        sh_val <= in_a;
                        cnt    <= in_b[SHAMT_W-1:0] - SHAMT_W'(1);
                        state  <= ST_SHIFT;
                     end
                  end else begin
                     out_valid   <= 1'b1;
                     out_result  <= c_result;
                     out_flags   <= c_flags;
                     out_wb      <= c_wb;
                     out_illegal <= c_illegal;
                  end
               end
            end
            ST_SHIFT: begin
               sh_val <= sh_nxt;
               if (cnt == '0) begin
                  out_valid   <= 1'b1;
                  out_result  <= sh_nxt;
                  out_flags   <= {(sh_nxt == '0), sh_nxt[M], sh_out, 1'b0};
                  out_wb      <= 1'b1;
                  out_illegal <= 1'b0;
                  state       <= ST_IDLE;
               end else begin
                  cnt <= cnt - SHAMT_W'(1);
               end
            end
`ifdef ALU_MUL_EN
            ST_MUL: begin
               acc    <= acc_nxt;
               mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
               mplier <= {1'b0, mplier[M:1]};
               if (cnt == '0) begin
                  out_valid   <= 1'b1;
                  out_result  <= acc_nxt[M:0];
                  out_flags   <= {(acc_nxt[M:0] == '0), acc_nxt[M],
                                  |acc_nxt[2*WIDTH-1:WIDTH], 1'b0};
                  out_wb      <= 1'b1;
                  out_illegal <= 1'b0;
                  state       <= ST_IDLE;
               end else begin
                  cnt <= cnt - SHAMT_W'(1);
               end
            end
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq (WIDTH=16). Expected values come
// from an arithmetic reference model; MUL checks follow ALU_MUL_EN.
module tb_alu_seq;
   import alu_pkg::*;

   localparam int     W   = 16;
   localparam longint MOD = 64'd1 << W;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b1;
   alu_op_e       in_op = OP_ADD;
   logic [W-1:0]  in_a = '0;
   logic [W-1:0]  in_b = '0;
   logic          in_ready;
   logic          out_valid;
   logic [W-1:0]  out_result;
   logic [3:0]    out_flags;
   logic          out_wb;
   logic          out_illegal;

   int checks = 0;
   int errors = 0;

   alu_seq #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_op       (in_op),
      .in_a        (in_a),
      .in_b        (in_b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_flags   (out_flags),
      .out_wb      (out_wb),
      .out_illegal (out_illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Reference: result, {Z,N,C,V}, wb, illegal and clocks from accept edge to result
   function automatic void model(input int op, input longint a, input longint b,
                                 output longint res, output logic [3:0] fl,
                                 output logic wb, output logic ill, output int lat);
      longint half, sa, sb, sr, full;
      logic   c, v;
      half = MOD / 2;
      sa = (a >= half) ? a - MOD : a;
      sb = (b >= half) ? b - MOD : b;
      res = 0; c = 0; v = 0; wb = 1; ill = 0; lat = 0; sr = 0;
      case (op)
         0: begin full = a + b; res = full % MOD; c = (full >= MOD);
                  sr = sa + sb; v = (sr >= half) || (sr < -half); end
         1, 2: begin res = (a - b + MOD) % MOD; c = (a < b);
                  sr = sa - sb; v = (sr >= half) || (sr < -half); wb = (op == 1); end
         3: res = a & b;
         4: res = a | b;
         5: res = a ^ b;
         6: res = (MOD - 1) - b;
         7: begin res = (MOD - b) % MOD; c = (b != 0);
                  sr = -sb; v = (sr >= half) || (sr < -half); end
         8, 9, 10: begin
            if (b == 0) res = a;
            else if (b >= W) begin
               if (op == 10 && a >= half) begin res = MOD - 1; c = 1; end
            end else begin
               lat = int'(b);
               if (op == 8) begin
                  res = (a << b) % MOD;
                  c = ((a >> (W - b)) & 1) != 0;
               end else begin
                  c = ((a >> (b - 1)) & 1) != 0;
                  res = (op == 9) ? (a >> b) : (((sa >>> b) + MOD) % MOD);
               end
            end
         end
         11: res = b;
`ifdef ALU_MUL_EN
         12: begin full = a * b; res = full % MOD; c = (full >= MOD); lat = W; end
`endif
         default: begin ill = 1; wb = 0; end
      endcase
      fl = ill ? 4'b0000 : {res == 0, res >= half, c, v};
   endfunction

   // Drive one request (called at a negedge), report what came out and when
   task automatic run_op(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] res, output logic [3:0] fl,
                         output logic wb, output logic ill, output int lat,
                         output int busy, output bit ok);
      int t;
      ok = 1;
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_op = alu_op_e'(op[3:0]);
      in_a = a;
      in_b = b;
      t = 0;
      while (!in_ready && t < 100) begin @(negedge clk); t++; end
      if (!in_ready) ok = 0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      busy = 0;
      while (!out_valid && lat < 100) begin
         if (!in_ready) busy++;
         @(negedge clk);
         lat++;
      end
      if (!out_valid) ok = 0;
      res = out_result;
      fl  = out_flags;
      wb  = out_wb;
      ill = out_illegal;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_result !== '0 ||
          out_flags !== 4'b0 || out_wb !== 1'b0 || out_illegal !== 1'b0)
         begin errors++; $display("FAIL reset_state: rdy=%b vld=%b res=%h fl=%b wb=%b ill=%b exp 0 0 0000 0000 0 0",
                                  in_ready, out_valid, out_result, out_flags, out_wb, out_illegal); end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b exp 1", in_ready); end
      @(negedge clk);
   endtask

   task automatic test_arith();
      logic [W-1:0] r; logic [3:0] f; logic wb, il; int lat, busy; bit ok;
      run_op(0, 16'hFFFF, 16'h0001, r, f, wb, il, lat, busy, ok);
      checks++;
      if (!ok || r !== 16'h0000 || f !== 4'b1010 || wb !== 1'b1 || lat != 0)
         begin errors++; $display("FAIL add_wrap: res=%h fl=%b wb=%b lat=%0d exp 0000 1010 1 0", r, f, wb, lat); end
      run_op(1, 16'h8000, 16'h0001, r, f, wb, il, lat, busy, ok);
      checks++;
      if (!ok || r !== 16'h7FFF || f !== 4'b0001 || wb !== 1'b1)
         begin errors++; $display("FAIL sub_ovf: res=%h fl=%b wb=%b exp 7fff 0001 1", r, f, wb); end
      run_op(2, 16'h0003, 16'h0005, r, f, wb, il, lat, busy, ok);
      checks++;
      if (!ok || r !== 16'hFFFE || f !== 4'b0110 || wb !== 1'b0)
         begin errors++; $display("FAIL cmp_borrow: res=%h fl=%b wb=%b exp fffe 0110 0", r, f, wb); end
      run_op(7, 16'h0000, 16'h8000, r, f, wb, il, lat, busy, ok);
      checks++;
      if (!ok || r !== 16'h8000 || f !== 4'b0111)
         begin errors++; $display("FAIL neg_min: res=%h fl=%b exp 8000 0111", r, f); end
   endtask

   task automatic test_shift();
      logic [W-1:0] r; logic [3:0] f; logic wb, il; int lat, busy; bit ok;
      longint er; logic [3:0] ef; logic ewb, eil; int elat;
      run_op(8, 16'h8001, 16'd4, r, f, wb, il, lat, busy, ok);
      checks++;
      if (!ok || r !== 16'h0010 || f !== 4'b0000 || lat != 4 || busy != 4)
         begin errors++; $display("FAIL shl_4: res=%h fl=%b lat=%0d busy=%0d exp 0010 0000 4 4", r, f, lat, busy); end
      run_op(10, 16'h8000, 16'd3, r, f, wb, il, lat, busy, ok);
      checks++;
      if (!ok || r !== 16'hF000 || f !== 4'b0100 || lat != 3)
         begin errors++; $display("FAIL sar_3: res=%h fl=%b lat=%0d exp f000 0100 3", r, f, lat); end
      run_op(9, 16'h00FF, 16'd20, r, f, wb, il, lat, busy, ok);
      checks++;
      if (!ok || r !== 16'h0000 || f !== 4'b1000 || lat != 0)
         begin errors++; $display("FAIL shr_big: res=%h fl=%b lat=%0d exp 0000 1000 0", r, f, lat); end
      for (int i = 0; i < 30; i++) begin
         int op; logic [W-1:0] a, b;
         op = $urandom_range(8, 10);
         a = W'($urandom);
         b = W'($urandom_range(0, 20));
         run_op(op, a, b, r, f, wb, il, lat, busy, ok);
         model(op, longint'(a), longint'(b), er, ef, ewb, eil, elat);
         checks++;
         if (!ok || r !== W'(er) || f !== ef || wb !== ewb || lat != elat)
            begin errors++; $display("FAIL shift_rand op=%0d a=%h b=%0d: res=%h fl=%b wb=%b lat=%0d exp %h %b %b %0d",
                                     op, a, b, r, f, wb, lat, W'(er), ef, ewb, elat); end
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] a1, b1, a2, b2, e_add;
      a1 = W'($urandom); b1 = W'($urandom); a2 = W'($urandom); b2 = W'($urandom);
      e_add = a1 + b1;
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk); @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b1; in_op = OP_ADD; in_a = a1; in_b = b1;
      @(posedge clk); @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_result !== e_add)
         begin errors++; $display("FAIL bp_first: vld=%b res=%h exp 1 %h", out_valid, out_result, e_add); end
      in_op = OP_XOR; in_a = a2; in_b = b2;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== e_add)
            begin errors++; $display("FAIL bp_hold cyc %0d: rdy=%b vld=%b res=%h exp 0 1 %h",
                                     i, in_ready, out_valid, out_result, e_add); end
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b exp 1", in_ready); end
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_result !== (a2 ^ b2) || out_wb !== 1'b1)
         begin errors++; $display("FAIL bp_swap: vld=%b res=%h wb=%b exp 1 %h 1", out_valid, out_result, out_wb, a2 ^ b2); end
      @(posedge clk); @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: vld=%b exp 0", out_valid); end
   endtask

   task automatic test_mul();
      logic [W-1:0] r; logic [3:0] f; logic wb, il; int lat, busy; bit ok;
`ifdef ALU_MUL_EN
      longint er; logic [3:0] ef; logic ewb, eil; int elat;
      bit seen;
      run_op(12, 16'h0100, 16'h0100, r, f, wb, il, lat, busy, ok);
      checks++;
      if (!ok || r !== 16'h0000 || f !== 4'b1010 || lat != W || wb !== 1'b1)
         begin errors++; $display("FAIL mul_ovf: res=%h fl=%b lat=%0d wb=%b exp 0000 1010 16 1", r, f, lat, wb); end
      for (int i = 0; i < 6; i++) begin
         logic [W-1:0] a, b;
         a = W'($urandom); b = (i < 3) ? W'($urandom_range(0, 255)) : W'($urandom);
         run_op(12, a, b, r, f, wb, il, lat, busy, ok);
         model(12, longint'(a), longint'(b), er, ef, ewb, eil, elat);
         checks++;
         if (!ok || r !== W'(er) || f !== ef || lat != elat)
            begin errors++; $display("FAIL mul_rand a=%h b=%h: res=%h fl=%b lat=%0d exp %h %b %0d",
                                     a, b, r, f, lat, W'(er), ef, elat); end
      end
      in_valid = 1'b1; in_op = OP_MUL; in_a = 16'h1234; in_b = 16'h5678; out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_result !== '0 ||
          out_flags !== 4'b0 || out_wb !== 1'b0 || out_illegal !== 1'b0)
         begin errors++; $display("FAIL mul_reset_outputs: rdy=%b vld=%b res=%h fl=%b wb=%b ill=%b exp all 0",
                                  in_ready, out_valid, out_result, out_flags, out_wb, out_illegal); end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (W + 4) begin @(negedge clk); if (out_valid) seen = 1; end
      checks++;
      if (seen || in_ready !== 1'b1)
         begin errors++; $display("FAIL mul_abandon: seen_valid=%b rdy=%b exp 0 1", seen, in_ready); end
`else
      run_op(12, 16'h0100, 16'h0100, r, f, wb, il, lat, busy, ok);
      checks++;
      if (!ok || r !== '0 || f !== 4'b0 || wb !== 1'b0 || il !== 1'b1 || lat != 0)
         begin errors++; $display("FAIL mul_illegal: res=%h fl=%b wb=%b ill=%b lat=%0d exp 0000 0000 0 1 0",
                                  r, f, wb, il, lat); end
`endif
   endtask

   task automatic test_illegal();
      logic [W-1:0] r; logic [3:0] f; logic wb, il; int lat, busy; bit ok;
      for (int op = 13; op <= 15; op++) begin
         run_op(op, W'($urandom), W'($urandom), r, f, wb, il, lat, busy, ok);
         checks++;
         if (!ok || r !== '0 || f !== 4'b0 || wb !== 1'b0 || il !== 1'b1 || lat != 0)
            begin errors++; $display("FAIL illegal_op%0d: res=%h fl=%b wb=%b ill=%b lat=%0d exp 0000 0000 0 1 0",
                                     op, r, f, wb, il, lat); end
      end
   endtask

   task automatic test_random();
      logic [W-1:0] r; logic [3:0] f; logic wb, il; int lat, busy; bit ok;
      longint er; logic [3:0] ef; logic ewb, eil; int elat;
      for (int i = 0; i < 120; i++) begin
         int op; logic [W-1:0] a, b;
         op = $urandom_range(0, 15);
         a = W'($urandom);
         b = W'($urandom);
         if (op >= 8 && op <= 10 && $urandom_range(0, 3) != 0) b = W'($urandom_range(0, 17));
         run_op(op, a, b, r, f, wb, il, lat, busy, ok);
         model(op, longint'(a), longint'(b), er, ef, ewb, eil, elat);
         checks++;
         if (!ok || r !== W'(er) || f !== ef || wb !== ewb || il !== eil || lat != elat)
            begin errors++; $display("FAIL rand op=%0d a=%h b=%h: res=%h fl=%b wb=%b ill=%b lat=%0d exp %h %b %b %b %0d",
                                     op, a, b, r, f, wb, il, lat, W'(er), ef, ewb, eil, elat); end
      end
   endtask

   initial begin
      test_reset();
      test_arith();
      test_shift();
      test_backpressure();
      test_mul();
      test_illegal();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
